mips_alu_issue: RTL and testbench



---
 rtl/mips_alu_issue.sv | 209 ++++++++++++++++++++
 tb/tb_mips_alu_issue.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_alu_issue.sv
`default_nettype none
// ============================================================================
// Module   : mips_alu_issue
// Brief    : Issue/writeback controller driving a 32-bit MIPS ALU: decode,
//            operand prep, one-cycle ALU settle, held result stage.
//            Optional macro MIPS_ALU_OVF_TRAP_EN enables the signed-overflow trap.
// Revision : 1.0  initial release
// ============================================================================
module mips_alu_issue (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic [2:0]  alu_opr,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic        alu_cin,
  input  logic [31:0] alu_res,
  input  logic        alu_zf,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_res,
  output logic        out_zf,
  output logic        out_ovf,
  output logic        out_ill,
  output logic [4:0]  out_wreg
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [2:0] OP_NONE = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_AND  = 3'b011;
  localparam logic [2:0] OP_OR   = 3'b100;
  localparam logic [2:0] OP_XOR  = 3'b101;
  localparam logic [2:0] OP_SLT  = 3'b110;

  logic [1:0]  r_state;
  logic [1:0]  w_next;

  logic [5:0]  w_opcode;
  logic [5:0]  w_funct;
  logic [31:0] w_simm;
  logic [31:0] w_zimm;
  logic [2:0]  w_opr;
  logic [31:0] w_b;
  logic [4:0]  w_dst;
  logic        w_ill;
  logic        w_sadd;
  logic        w_ssub;
  logic        w_accept;

  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [2:0]  r_opr;
  logic [4:0]  r_dst;
  logic        r_ill;
  logic [31:0] r_res;
  logic        r_zf;
  logic        r_out_ill;
  logic [4:0]  r_wreg;
  logic        w_wb_kill;

  // rs field is not needed: the operand value arrives on rs_data
  logic w_unused_rs;
  assign w_unused_rs = ^instr[25:21];

  assign w_opcode = instr[31:26];
  assign w_funct  = instr[5:0];
  assign w_simm   = {{16{instr[15]}}, instr[15:0]};
  assign w_zimm   = {16'd0, instr[15:0]};
  assign w_accept = (r_state == S_IDLE) && in_valid;

  always_comb begin
    w_opr  = OP_NONE;
    w_b    = rt_data;
    w_dst  = 5'd0;
    w_ill  = 1'b1;
    w_sadd = 1'b0;
    w_ssub = 1'b0;
    case (w_opcode)
      6'b000000: begin
        w_ill = 1'b0;
        w_dst = instr[15:11];
        case (w_funct)
          6'b100000: begin w_opr = OP_ADD; w_sadd = 1'b1; end
          6'b100001: w_opr = OP_ADD;
          6'b100010: begin w_opr = OP_SUB; w_ssub = 1'b1; end
          6'b100011: w_opr = OP_SUB;
          6'b100100: w_opr = OP_AND;
          6'b100101: w_opr = OP_OR;
          6'b100110: w_opr = OP_XOR;
          6'b101010: w_opr = OP_SLT;
          default: begin
            w_ill = 1'b1;
            w_dst = 5'd0;
          end
        endcase
      end
      6'b001000: begin w_opr = OP_ADD; w_b = w_simm; w_dst = instr[20:16]; w_ill = 1'b0; w_sadd = 1'b1; end
      6'b001001: begin w_opr = OP_ADD; w_b = w_simm; w_dst = instr[20:16]; w_ill = 1'b0; end
      6'b001010: begin w_opr = OP_SLT; w_b = w_simm; w_dst = instr[20:16]; w_ill = 1'b0; end
      6'b001100: begin w_opr = OP_AND; w_b = w_zimm; w_dst = instr[20:16]; w_ill = 1'b0; end
      6'b001101: begin w_opr = OP_OR;  w_b = w_zimm; w_dst = instr[20:16]; w_ill = 1'b0; end
      6'b001110: begin w_opr = OP_XOR; w_b = w_zimm; w_dst = instr[20:16]; w_ill = 1'b0; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (in_valid) w_next = S_EXEC;
      S_EXEC:  w_next = S_DONE;
      S_DONE:  if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // alu_opr falls to 000 only in IDLE so a latch-style ALU keeps its result through DONE
  always_comb begin
    in_ready  = (r_state == S_IDLE);
    out_valid = (r_state == S_DONE);
    alu_opr   = (r_state == S_IDLE) ? OP_NONE : r_opr;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a   <= 32'd0;
      r_b   <= 32'd0;
      r_opr <= OP_NONE;
      r_dst <= 5'd0;
      r_ill <= 1'b0;
    end else if (w_accept) begin
      r_a   <= rs_data;
      r_b   <= w_b;
      r_opr <= w_opr;
      r_dst <= w_dst;
      r_ill <= w_ill;
    end
  end

`ifdef MIPS_ALU_OVF_TRAP_EN
  logic r_sadd;
  logic r_ssub;
  logic r_ovf;
  logic w_ovf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sadd <= 1'b0;
      r_ssub <= 1'b0;
    end else if (w_accept) begin
      r_sadd <= w_sadd;
      r_ssub <= w_ssub;
    end
  end

  assign w_ovf = (r_sadd && (r_a[31] == r_b[31]) && (alu_res[31] != r_a[31])) ||
                 (r_ssub && (r_a[31] != r_b[31]) && (alu_res[31] != r_a[31]));
  assign w_wb_kill = w_ovf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      r_ovf <= 1'b0;
    else if (r_state == S_EXEC)   r_ovf <= w_ovf;
  end
  assign out_ovf = r_ovf;
`else
  logic w_unused_sgn;
  assign w_unused_sgn = w_sadd ^ w_ssub;
  assign w_wb_kill    = 1'b0;
  assign out_ovf      = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_res     <= 32'd0;
      r_zf      <= 1'b0;
      r_out_ill <= 1'b0;
      r_wreg    <= 5'd0;
    end else if (r_state == S_EXEC) begin
      r_res     <= r_ill ? 32'd0 : alu_res;
      r_zf      <= r_ill ? 1'b0 : alu_zf;
      r_out_ill <= r_ill;
      r_wreg    <= w_wb_kill ? 5'd0 : r_dst;
    end
  end

  assign alu_a    = r_a;
  assign alu_b    = r_b;
  assign alu_cin  = 1'b0;
  assign out_res  = r_res;
  assign out_zf   = r_zf;
  assign out_ill  = r_out_ill;
  assign out_wreg = r_wreg;

endmodule
`default_nettype wire

// File: tb/tb_mips_alu_issue.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_alu_issue
// Brief    : Vector table plus scoreboard bench for mips_alu_issue with a
//            behavioural ALU partner. Honors MIPS_ALU_OVF_TRAP_EN.
// Revision : 1.0  initial release
// ============================================================================
module tb_mips_alu_issue;

`ifdef MIPS_ALU_OVF_TRAP_EN
  localparam bit c_TRAP = 1'b1;
`else
  localparam bit c_TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] instr = 32'd0;
  logic [31:0] rs_data = 32'd0;
  logic [31:0] rt_data = 32'd0;
  logic [2:0]  alu_opr;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic        alu_cin;
  logic [31:0] alu_res;
  logic        alu_zf;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_res;
  logic        out_zf;
  logic        out_ovf;
  logic        out_ill;
  logic [4:0]  out_wreg;

  always #5 clk = ~clk;

  mips_alu_issue dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .rs_data(rs_data), .rt_data(rt_data),
    .alu_opr(alu_opr), .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin),
    .alu_res(alu_res), .alu_zf(alu_zf),
    .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res),
    .out_zf(out_zf), .out_ovf(out_ovf), .out_ill(out_ill), .out_wreg(out_wreg)
  );

  // ALU partner; SLT is an unsigned compare
  always_comb begin
    case (alu_opr)
      3'b001:  alu_res = alu_a + alu_b;
      3'b010:  alu_res = alu_a - alu_b;
      3'b011:  alu_res = alu_a & alu_b;
      3'b100:  alu_res = alu_a | alu_b;
      3'b101:  alu_res = alu_a ^ alu_b;
      3'b110:  alu_res = (alu_a < alu_b) ? 32'd1 : 32'd0;
      default: alu_res = 32'd0;
    endcase
    alu_zf = (alu_res == 32'd0);
  end

  typedef struct {
    logic [31:0] instr;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [2:0]  opr;
    logic [31:0] b;
    bit          chk_b;
    logic [31:0] res;
    logic        zf;
    logic        ovf;
    logic        ill;
    logic [4:0]  wreg;
  } vec_t;

  int   total = 0;
  int   bad   = 0;
  vec_t q[$];
  vec_t tbl[16];

  function automatic logic [31:0] rtype(logic [4:0] rd, logic [5:0] fn);
    return {6'd0, 5'd1, 5'd2, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(logic [5:0] op, logic [4:0] rt, logic [15:0] imm);
    return {op, 5'd1, rt, imm};
  endfunction

  function automatic vec_t mk(logic [31:0] i, logic [31:0] rs, logic [31:0] rt,
                              logic [2:0] opr, logic [31:0] b, bit chk_b,
                              logic [31:0] res, logic zf, logic ovf, logic ill,
                              logic [4:0] wreg);
    vec_t v;
    v.instr = i; v.rs = rs; v.rt = rt; v.opr = opr; v.b = b; v.chk_b = chk_b;
    v.res = res; v.zf = zf; v.ovf = ovf; v.ill = ill; v.wreg = wreg;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("accept_timeout", in_ready, 1);
  endtask

  // Handshake at the next edge, then check the EXEC-cycle ALU drive
  task automatic issue(vec_t v);
    wait_ready();
    instr = v.instr; rs_data = v.rs; rt_data = v.rt; in_valid = 1'b1;
    @(posedge clk);
    q.push_back(v);
    #1;
    in_valid = 1'b0;
    chk("exec_opr", alu_opr, v.opr);
    chk("exec_a", alu_a, v.rs);
    if (v.chk_b) chk("exec_b", alu_b, v.b);
    chk("exec_in_ready", in_ready, 0);
    chk("exec_out_valid", out_valid, 0);
  endtask

  task automatic compare_out();
    vec_t e;
    if (out_valid && q.size() > 0) begin
      e = q.pop_front();
      chk("out_res", out_res, e.res);
      if (!e.ill) chk("out_zf", out_zf, e.zf);
      chk("out_ovf", out_ovf, e.ovf);
      chk("out_ill", out_ill, e.ill);
      chk("out_wreg", out_wreg, e.wreg);
    end else begin
      total++; bad++;
      $display("FAIL result_missing: out_valid=%0b queued=%0d", out_valid, q.size());
    end
  endtask

  task automatic collect();
    @(posedge clk); #1;
    chk("latency_out_valid", out_valid, 1);
    compare_out();
    @(posedge clk); #1;
    chk("back_in_ready", in_ready, 1);
    chk("back_out_valid", out_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tbl[0]  = mk(rtype(5'd3, 6'b100001), 32'h5, 32'h7, 3'b001, 32'h7, 1, 32'hC, 0, 0, 0, 5'd3);
    tbl[1]  = mk(rtype(5'd4, 6'b100000), 32'h7FFFFFFF, 32'h1, 3'b001, 32'h1, 1, 32'h80000000, 0, c_TRAP, 0, c_TRAP ? 5'd0 : 5'd4);
    tbl[2]  = mk(itype(6'b001100, 5'd9, 16'h8001), 32'hFFFF1234, 32'hDEAD, 3'b011, 32'h00008001, 1, 32'h0, 1, 0, 0, 5'd9);
    tbl[3]  = mk(itype(6'b001010, 5'd2, 16'hFFFF), 32'h5, 32'h0, 3'b110, 32'hFFFFFFFF, 1, 32'h1, 0, 0, 0, 5'd2);
    tbl[4]  = mk({6'h3F, 26'h0}, 32'h12345678, 32'h9, 3'b000, 32'h0, 0, 32'h0, 0, 0, 1, 5'd0);
    tbl[5]  = mk(rtype(5'd5, 6'b100010), 32'h80000000, 32'h1, 3'b010, 32'h1, 1, 32'h7FFFFFFF, 0, c_TRAP, 0, c_TRAP ? 5'd0 : 5'd5);
    tbl[6]  = mk(rtype(5'd6, 6'b100011), 32'hA, 32'hA, 3'b010, 32'hA, 1, 32'h0, 1, 0, 0, 5'd6);
    tbl[7]  = mk(rtype(5'd7, 6'b100101), 32'hF0F00000, 32'h00000F0F, 3'b100, 32'h00000F0F, 1, 32'hF0F00F0F, 0, 0, 0, 5'd7);
    tbl[8]  = mk(itype(6'b001110, 5'd8, 16'hFFFF), 32'hFFFF0000, 32'h0, 3'b101, 32'h0000FFFF, 1, 32'hFFFFFFFF, 0, 0, 0, 5'd8);
    tbl[9]  = mk(itype(6'b001000, 5'd10, 16'hFFF0), 32'h10, 32'h0, 3'b001, 32'hFFFFFFF0, 1, 32'h0, 1, 0, 0, 5'd10);
    tbl[10] = mk(itype(6'b001001, 5'd11, 16'h0001), 32'h7FFFFFFF, 32'h0, 3'b001, 32'h1, 1, 32'h80000000, 0, 0, 0, 5'd11);
    tbl[11] = mk(rtype(5'd12, 6'b100110), 32'hA5A5A5A5, 32'hFFFFFFFF, 3'b101, 32'hFFFFFFFF, 1, 32'h5A5A5A5A, 0, 0, 0, 5'd12);
    tbl[12] = mk(rtype(5'd13, 6'b101010), 32'h1, 32'hFFFFFFFF, 3'b110, 32'hFFFFFFFF, 1, 32'h1, 0, 0, 0, 5'd13);
    tbl[13] = mk(rtype(5'd14, 6'b100111), 32'h1, 32'h2, 3'b000, 32'h0, 0, 32'h0, 0, 0, 1, 5'd0);
    tbl[14] = mk(rtype(5'd14, 6'b100100), 32'hFF00FF00, 32'h0F0F0F0F, 3'b011, 32'h0F0F0F0F, 1, 32'h0F000F00, 0, 0, 0, 5'd14);
    tbl[15] = mk(itype(6'b001000, 5'd15, 16'h0001), 32'h7FFFFFFF, 32'h0, 3'b001, 32'h1, 1, 32'h80000000, 0, c_TRAP, 0, c_TRAP ? 5'd0 : 5'd15);

    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_alu_opr", alu_opr, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_out_res", out_res, 0);
    chk("rst_out_wreg", out_wreg, 0);
    chk("rst_alu_cin", alu_cin, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 16; i++) begin
      issue(tbl[i]);
      collect();
    end

    // Backpressure: result held while a second instruction waits on in_valid
    begin
      vec_t e;
      out_ready = 1'b0;
      issue(tbl[7]);
      @(posedge clk); #1;
      chk("bp_out_valid", out_valid, 1);
      e = q[0];
      compare_out();
      instr = tbl[8].instr; rs_data = tbl[8].rs; rt_data = tbl[8].rt; in_valid = 1'b1;
      for (int c = 0; c < 5; c++) begin
        @(posedge clk); #1;
        chk("bp_hold_valid", out_valid, 1);
        chk("bp_hold_res", out_res, e.res);
        chk("bp_hold_wreg", out_wreg, e.wreg);
        chk("bp_in_ready", in_ready, 0);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp_release_in_ready", in_ready, 1);
      chk("bp_release_out_valid", out_valid, 0);
      @(posedge clk);
      q.push_back(tbl[8]);
      #1;
      in_valid = 1'b0;
      chk("bp_second_opr", alu_opr, tbl[8].opr);
      chk("bp_second_in_ready", in_ready, 0);
      collect();
    end

    // Asynchronous reset during EXEC drops the in-flight instruction
    issue(tbl[11]);
    collect();
    issue(tbl[1]);
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_alu_opr", alu_opr, 0);
    chk("mid_rst_alu_a", alu_a, 0);
    chk("mid_rst_alu_b", alu_b, 0);
    chk("mid_rst_out_res", out_res, 0);
    chk("mid_rst_out_zf", out_zf, 0);
    chk("mid_rst_out_ovf", out_ovf, 0);
    chk("mid_rst_out_ill", out_ill, 0);
    chk("mid_rst_out_wreg", out_wreg, 0);
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      chk("dropped_no_valid", out_valid, 0);
    end

    issue(tbl[0]);
    collect();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
